fifo_ctrl_16x8: RTL and testbench
=================================

Name: fifo_ctrl_16x8

Overview:
Synchronous FIFO controller that sequences the 16x8 dual-port synchronous RAM (dual_syn_ram_16x8) as FIFO storage. It turns push/pop requests into RAM write/read strobes and addresses, and tracks occupancy, full/empty and error pulses. The RAM's registered read adds one cycle of latency, which the controller marks with dout_valid. The parent (fifo_16x8) instantiates this controller and the RAM side by side and ties the RAM's rst inactive; RAM contents are irrelevant while the FIFO is empty.

Parameters:
WIDTH, 8, data width; must match the RAM.
DEPTH, 16, entries; power of two, equals 2**ADDR_BUS.
ADDR_BUS, 4, RAM address width.
AF_LEVEL, 12, almost_full threshold in entries.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
push  in  1  write request
pop  in  1  read request
din  in  WIDTH  write data
dout  out  WIDTH  read data, = ram_dout passthrough
dout_valid  out  1  dout holds popped data this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
count  out  ADDR_BUS+1  occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: push was rejected
underflow  out  1  one-cycle pulse: pop was rejected
ram_we  out  1  to RAM we
ram_re  out  1  to RAM re
ram_wr_addr  out  ADDR_BUS  to RAM wr_addr
ram_rd_addr  out  ADDR_BUS  to RAM rd_addr
ram_din  out  WIDTH  to RAM din, = din
ram_dout  in  WIDTH  from RAM dout

Behaviour:
- Reset: rst low clears wr_ptr, rd_ptr, dout_valid, overflow and underflow to 0 immediately, without waiting for a clock edge. The combinational outputs then read count=0, empty=1, full=0, almost_full=0, ram_we=0, ram_re=0.
- Pointers: wr_ptr and rd_ptr are ADDR_BUS+1 bits wide. The low ADDR_BUS bits drive the RAM addresses. The MSB is a wrap bit; a pointer advances from 5'd31 back to 5'd0.
- count = wr_ptr - rd_ptr, modulo 2**(ADDR_BUS+1). empty = (count == 0); full = (count == DEPTH). All flags are combinational from the pointers.
- pop_acc = pop & !empty.
- push_acc = push & (!full | pop_acc). When full, a push is accepted only if a pop is accepted in the same cycle.
- ram_we = push_acc and ram_re = pop_acc, both combinational. ram_wr_addr = wr_ptr[ADDR_BUS-1:0]; ram_rd_addr = rd_ptr[ADDR_BUS-1:0].
- On each clock edge, wr_ptr increments if push_acc and rd_ptr increments if pop_acc.
- Read latency: dout_valid is registered pop_acc, so it is high exactly one cycle after the accepted pop. dout shows the RAM's registered output in that cycle.
- Push and pop when empty: the pop is rejected (underflow pulses) and the push is accepted. The written data is poppable no earlier than the next cycle.
- Push and pop when full: both are accepted and count stays at DEPTH. Write and read hit the same address; the RAM's non-blocking update returns the old (oldest) entry, which is the correct FIFO order.
- Push and pop when partially filled: both are accepted and count is unchanged.
- overflow is registered (push & !push_acc); underflow is registered (pop & !pop_acc). Each is a one-cycle pulse in the cycle after the rejected request. Pulses are not sticky.
- Reset mid-operation: an in-flight read is discarded (dout_valid forced to 0) and all stored data is logically lost.

Decomposition:
- Shared package fifo_pkg: WIDTH, DEPTH, ADDR_BUS, AF_LEVEL defaults, and the pointer width constant PTR_W = ADDR_BUS+1.
- One sub-module, fifo_ptr: an enabled PTR_W-bit wrap counter with async active-low reset. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- Reset: assert rst low mid-clock with 5 entries stored -> count=0, empty=1, dout_valid=0 before the next edge.
- Fill then drain: push 0x10..0x1F on 16 cycles -> full=1, count=16, almost_full rises at count=12. Pop 16 times -> dout 0x10..0x1F in order, dout_valid one cycle after each pop, empty=1 at the end.
- Overflow: push 0xAA while full without pop -> overflow pulses one cycle, count stays 16, RAM not written.
- Underflow: pop while empty -> underflow pulses one cycle, dout_valid stays 0.
- Full with push+pop: full with head 0x10, push 0x99 and pop together -> dout=0x10 next cycle, count=16, 0x99 read out last.
- Wrap-around: run 40 push/pop pairs at occupancy 3 -> pointers wrap past 31, data order intact, count constant at 3.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared sizing constants for the 16x8 FIFO controller slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_WIDTH    = 8;
    localparam int FIFO_DEPTH    = 16;
    localparam int FIFO_ADDR_BUS = 4;
    localparam int FIFO_AF_LEVEL = 12;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    localparam int PTR_W = FIFO_ADDR_BUS + 1;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : Enabled wrap-around pointer counter with asynchronous
//                active-low reset. Wraps naturally from all-ones to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int CNT_W = PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] ptr
);

    logic [CNT_W-1:0] ptr_d;
    logic [CNT_W-1:0] ptr_q;

    // Next pointer value: advance by one when enabled, modulo 2**CNT_W.
    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + CNT_W'(1);
        end
    end

    // Pointer register, cleared immediately on reset assertion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_ctrl_16x8.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_16x8
//  Description : Synchronous FIFO controller sequencing a 16x8 dual-port RAM
//                with registered read. Generates RAM strobes/addresses,
//                occupancy, flags, read-valid and error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_16x8
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int ADDR_BUS = FIFO_ADDR_BUS,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic [ADDR_BUS:0]   count,
    output logic                overflow,
    output logic                underflow,
    output logic                ram_we,
    output logic                ram_re,
    output logic [ADDR_BUS-1:0] ram_wr_addr,
    output logic [ADDR_BUS-1:0] ram_rd_addr,
    output logic [WIDTH-1:0]    ram_din,
    input  logic [WIDTH-1:0]    ram_dout
);

    localparam int                CNT_W   = ADDR_BUS + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             pop_acc;
    logic             push_acc;

    logic dout_valid_d, dout_valid_q;
    logic overflow_d,   overflow_q;
    logic underflow_d,  underflow_q;

    fifo_ptr #(.CNT_W(CNT_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.CNT_W(CNT_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_acc),
        .ptr (rd_ptr)
    );

    // Occupancy, flags and request acceptance; a push into a full FIFO is
    // allowed only when a pop frees the head slot in the same cycle.
    always_comb begin
        count    = wr_ptr - rd_ptr;
        empty    = (count == '0);
        full     = (count == C_DEPTH);
        almost_full = (count >= C_AF);
        pop_acc  = pop & ~empty;
        push_acc = push & (~full | pop_acc);
        dout_valid_d = pop_acc;
        overflow_d   = push & ~push_acc;
        underflow_d  = pop & ~pop_acc;
    end

    // Read-valid and error pulse registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign ram_we      = push_acc;
    assign ram_re      = pop_acc;
    assign ram_wr_addr = wr_ptr[ADDR_BUS-1:0];
    assign ram_rd_addr = rd_ptr[ADDR_BUS-1:0];
    assign ram_din     = din;
    assign dout        = ram_dout;
    assign dout_valid  = dout_valid_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule : fifo_ctrl_16x8
`default_nettype wire

// File: tb/tb_fifo_ctrl_16x8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_ctrl_16x8
//  Description : Directed self-checking bench for fifo_ctrl_16x8 with a
//                behavioural registered-read 16x8 RAM alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_16x8;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       ram_we;
    logic       ram_re;
    logic [3:0] ram_wr_addr;
    logic [3:0] ram_rd_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [3:0] mwr;
    logic [3:0] mrd;

    logic [7:0] mem [16];

    fifo_ctrl_16x8 dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered read (old data on collision)
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus starting just after a rising edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d);
        logic       pa;
        logic       wa;
        logic [7:0] exp_d;
        int         n;
        push = p; pop = q; din = d;
        exp_d = 8'h00;
        n  = mq.size();
        pa = q && (n != 0);
        wa = p && ((n != 16) || pa);
        #3;
        chk("ram_we", {31'd0, ram_we}, {31'd0, wa});
        chk("ram_re", {31'd0, ram_re}, {31'd0, pa});
        if (wa) chk("ram_wr_addr", {28'd0, ram_wr_addr}, {28'd0, mwr});
        if (pa) chk("ram_rd_addr", {28'd0, ram_rd_addr}, {28'd0, mrd});
        @(posedge clk); #1;
        if (pa) begin exp_d = mq.pop_front(); mrd = mrd + 4'd1; end
        if (wa) begin mq.push_back(d); mwr = mwr + 4'd1; end
        n = mq.size();
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, pa});
        if (pa) chk("dout", {24'd0, dout}, {24'd0, exp_d});
        chk("overflow",  {31'd0, overflow},  {31'd0, (p && !wa)});
        chk("underflow", {31'd0, underflow}, {31'd0, (q && !pa)});
        chk("count", {27'd0, count}, 32'(n));
        chk("empty", {31'd0, empty}, {31'd0, (n == 0)});
        chk("full",  {31'd0, full},  {31'd0, (n == 16)});
        chk("almost_full", {31'd0, almost_full}, {31'd0, (n >= 12)});
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; din = 8'h00;
        mwr = 4'd0; mrd = 4'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        // Reset state
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_af", {31'd0, almost_full}, 32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_re", {31'd0, ram_re}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Fill with 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'h10 + 8'(i));
            chk("fill_af_hand", {31'd0, almost_full}, {31'd0, (i >= 11)});
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_count", {27'd0, count}, 32'd16);

        // Overflow: push while full, no pop; RAM must not be written
        step(1'b1, 1'b0, 8'hAA);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf_clear", {31'd0, overflow}, 32'd0);

        // Full with simultaneous push+pop: head 0x10 out, 0x99 goes to tail
        step(1'b1, 1'b1, 8'h99);
        chk("fullpp_dout", {24'd0, dout}, 32'h10);
        chk("fullpp_count", {27'd0, count}, 32'd16);

        // Drain: 0x11..0x1F then 0x99
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain_dout", {24'd0, dout}, (i < 15) ? 32'h11 + 32'(i) : 32'h99);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        chk("drain_valid_low", {31'd0, dout_valid}, 32'd0);

        // Underflow
        step(1'b0, 1'b1, 8'h00);
        chk("udf_pulse", {31'd0, underflow}, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        chk("udf_clear", {31'd0, underflow}, 32'd0);

        // Push and pop together while empty: pop rejected, push accepted
        step(1'b1, 1'b1, 8'h55);
        chk("emptypp_udf", {31'd0, underflow}, 32'd1);
        chk("emptypp_count", {27'd0, count}, 32'd1);
        step(1'b0, 1'b1, 8'h00);
        chk("emptypp_dout", {24'd0, dout}, 32'h55);

        // Wrap-around at occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b1, 8'h23 + 8'(k));
            chk("wrap_dout", {24'd0, dout}, 32'h20 + 32'(k));
            chk("wrap_count", {27'd0, count}, 32'd3);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // Reset mid-operation with 5 entries stored and a read in flight
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
        step(1'b0, 1'b1, 8'h00);
        chk("pre_rst_valid", {31'd0, dout_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_count", {27'd0, count}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
        mq.delete(); mwr = 4'd0; mrd = 4'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst_udf", {31'd0, underflow}, 32'd1);
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst_dout", {24'd0, dout}, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_ctrl_16x8
`default_nettype wire
